normalizer_mul_pipe: RTL and testbench

NORMALIZER_MUL_PIPE -- requirements
Module: normalizer_mul_pipe

---
 rtl/normalizer_mul_pipe.sv | 174 +++++++++++++++++
 tb/tb_normalizer_mul_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/normalizer_mul_pipe.sv
// rtl/normalizer_mul_pipe.sv - two-stage elastic unpack/normalize front end for an FP multiplier
module normalizer_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127,
    localparam int W    = 1 + EXP_W + MAN_W,
    localparam int SH_W = $clog2(MAN_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            op_a,
    input  logic [W-1:0]            op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MAN_W:0]          a_man_norm,
    output logic [MAN_W:0]          b_man_norm,
    output logic [SH_W-1:0]         a_shift,
    output logic [SH_W-1:0]         b_shift,
    output logic signed [EXP_W+1:0] exp_sum,
    output logic                    result_sign,
    output logic                    is_zero,
    output logic                    is_inf,
    output logic                    is_nan
);

    // Leading-zero count; an all-zero significand reports 0 so it is left unshifted.
    function automatic logic [SH_W-1:0] lzc(input logic [MAN_W:0] sig);
        logic [SH_W-1:0] cnt;
        logic            found;
        cnt   = '0;
        found = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            if (!found) begin
                if (sig[i]) found = 1'b1;
                else        cnt   = cnt + SH_W'(1);
            end
        end
        return found ? cnt : '0;
    endfunction

    // Stage 1: unpacked fields and per-operand class bits {nan, inf, zero}
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]   s1_ea_q, s1_ea_d, s1_eb_q, s1_eb_d;
    logic [MAN_W:0]     s1_sig_a_q, s1_sig_a_d, s1_sig_b_q, s1_sig_b_d;
    logic [2:0]         s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;

    // Stage 2: normalized results, which are the block outputs
    logic                    s2_valid_q, s2_valid_d;
    logic [MAN_W:0]          s2_norm_a_q, s2_norm_a_d, s2_norm_b_q, s2_norm_b_d;
    logic [SH_W-1:0]         s2_sh_a_q, s2_sh_a_d, s2_sh_b_q, s2_sh_b_d;
    logic signed [EXP_W+1:0] s2_exp_q, s2_exp_d;
    logic                    s2_sign_q, s2_sign_d;
    logic [2:0]              s2_flags_q, s2_flags_d;

    logic s2_can_take;
    logic s1_load;
    logic s2_load;

    // Handshake: S2 can accept whenever it is empty or draining this cycle
    always_comb begin
        s2_can_take = !s2_valid_q || out_ready;
        in_ready    = rst_n && (!s1_valid_q || s2_can_take);
        s1_load     = in_valid && in_ready;
        s2_load     = s1_valid_q && s2_can_take;
    end

    // Stage 1 next state: unpack, build significands, classify operands
    always_comb begin
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] ma, mb;
        s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s1_sign_d  = s1_sign_q;
        s1_ea_d    = s1_ea_q;
        s1_eb_d    = s1_eb_q;
        s1_sig_a_d = s1_sig_a_q;
        s1_sig_b_d = s1_sig_b_q;
        s1_cls_a_d = s1_cls_a_q;
        s1_cls_b_d = s1_cls_b_q;
        ea = op_a[W-2 -: EXP_W];
        eb = op_b[W-2 -: EXP_W];
        ma = op_a[MAN_W-1:0];
        mb = op_b[MAN_W-1:0];
        if (s1_load) begin
            s1_sign_d  = op_a[W-1] ^ op_b[W-1];
            s1_ea_d    = (ea == '0) ? EXP_W'(1) : ea;
            s1_eb_d    = (eb == '0) ? EXP_W'(1) : eb;
            s1_sig_a_d = {(ea != '0), ma};
            s1_sig_b_d = {(eb != '0), mb};
            s1_cls_a_d = {(&ea) && (|ma), (&ea) && !(|ma), (ea == '0) && !(|ma)};
            s1_cls_b_d = {(&eb) && (|mb), (&eb) && !(|mb), (eb == '0) && !(|mb)};
        end
    end

    // Stage 2 next state: normalize significands, sum exponents, resolve specials
    always_comb begin
        logic nan, inf, zero;
        s2_valid_d  = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
        s2_norm_a_d = s2_norm_a_q;
        s2_norm_b_d = s2_norm_b_q;
        s2_sh_a_d   = s2_sh_a_q;
        s2_sh_b_d   = s2_sh_b_q;
        s2_exp_d    = s2_exp_q;
        s2_sign_d   = s2_sign_q;
        s2_flags_d  = s2_flags_q;
        nan  = s1_cls_a_q[2] || s1_cls_b_q[2] ||
               (s1_cls_a_q[1] && s1_cls_b_q[0]) || (s1_cls_b_q[1] && s1_cls_a_q[0]);
        inf  = (s1_cls_a_q[1] || s1_cls_b_q[1]) && !nan;
        zero = (s1_cls_a_q[0] || s1_cls_b_q[0]) && !nan && !inf;
        if (s2_load) begin
            s2_sh_a_d   = lzc(s1_sig_a_q);
            s2_sh_b_d   = lzc(s1_sig_b_q);
            s2_norm_a_d = s1_sig_a_q << s2_sh_a_d;
            s2_norm_b_d = s1_sig_b_q << s2_sh_b_d;
            s2_exp_d    = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q})
                          - $signed((EXP_W+2)'(BIAS));
            s2_sign_d   = s1_sign_q;
            s2_flags_d  = {zero, inf, nan};
        end
    end

    // Pipeline registers; reset empties both stages and zeroes the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_ea_q     <= '0;
            s1_eb_q     <= '0;
            s1_sig_a_q  <= '0;
            s1_sig_b_q  <= '0;
            s1_cls_a_q  <= '0;
            s1_cls_b_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_norm_a_q <= '0;
            s2_norm_b_q <= '0;
            s2_sh_a_q   <= '0;
            s2_sh_b_q   <= '0;
            s2_exp_q    <= '0;
            s2_sign_q   <= 1'b0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_ea_q     <= s1_ea_d;
            s1_eb_q     <= s1_eb_d;
            s1_sig_a_q  <= s1_sig_a_d;
            s1_sig_b_q  <= s1_sig_b_d;
            s1_cls_a_q  <= s1_cls_a_d;
            s1_cls_b_q  <= s1_cls_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_norm_a_q <= s2_norm_a_d;
            s2_norm_b_q <= s2_norm_b_d;
            s2_sh_a_q   <= s2_sh_a_d;
            s2_sh_b_q   <= s2_sh_b_d;
            s2_exp_q    <= s2_exp_d;
            s2_sign_q   <= s2_sign_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign a_man_norm  = s2_norm_a_q;
    assign b_man_norm  = s2_norm_b_q;
    assign a_shift     = s2_sh_a_q;
    assign b_shift     = s2_sh_b_q;
    assign exp_sum     = s2_exp_q;
    assign result_sign = s2_sign_q;
    assign is_zero     = s2_flags_q[2];
    assign is_inf      = s2_flags_q[1];
    assign is_nan      = s2_flags_q[0];

endmodule

// File: tb/tb_normalizer_mul_pipe.sv
// tb/tb_normalizer_mul_pipe.sv - directed self-checking bench for normalizer_mul_pipe
module tb_normalizer_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op_a, op_b;
    logic [23:0] a_man_norm, b_man_norm;
    logic [4:0]  a_shift, b_shift;
    logic signed [9:0] exp_sum;
    logic        result_sign, is_zero, is_inf, is_nan;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_op_a, h_op_b;
    logic [10:0] h_a_man_norm, h_b_man_norm;
    logic [3:0]  h_a_shift, h_b_shift;
    logic signed [6:0] h_exp_sum;
    logic        h_result_sign, h_is_zero, h_is_inf, h_is_nan;

    int tests_run    = 0;
    int tests_failed = 0;
    logic signed [9:0] exp_e;

    normalizer_mul_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .a_man_norm(a_man_norm), .b_man_norm(b_man_norm),
        .a_shift(a_shift), .b_shift(b_shift), .exp_sum(exp_sum),
        .result_sign(result_sign), .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan)
    );

    normalizer_mul_pipe #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op_a(h_op_a), .op_b(h_op_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .a_man_norm(h_a_man_norm), .b_man_norm(h_b_man_norm),
        .a_shift(h_a_shift), .b_shift(h_b_shift), .exp_sum(h_exp_sum),
        .result_sign(h_result_sign), .is_zero(h_is_zero), .is_inf(h_is_inf), .is_nan(h_is_nan)
    );

    always #5 clk = ~clk;

    // Drive one pair with out_ready high and return 2 edges after acceptance.
    task automatic send_one(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_op_a = '0; h_op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests_run++;
        if ({a_man_norm, exp_sum, is_nan} !== 35'd0) begin tests_failed++; $display("FAIL reset_data got %h/%0d/%b exp 0", a_man_norm, exp_sum, is_nan); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early got %b exp 0", out_valid); end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_2 got %b exp 1", out_valid); end
        tests_run++;
        if ({a_man_norm, b_man_norm} !== {24'h800000, 24'h800000}) begin tests_failed++; $display("FAIL basic_norm got %h %h exp 800000 800000", a_man_norm, b_man_norm); end
        tests_run++;
        if ({a_shift, b_shift} !== 10'd0) begin tests_failed++; $display("FAIL basic_shift got %0d %0d exp 0 0", a_shift, b_shift); end
        exp_e = 10'sd128;
        tests_run++;
        if (exp_sum !== exp_e) begin tests_failed++; $display("FAIL basic_exp got %0d exp %0d", exp_sum, exp_e); end
        tests_run++;
        if ({result_sign, is_zero, is_inf, is_nan} !== 4'b0000) begin tests_failed++; $display("FAIL basic_flags got %b exp 0000", {result_sign, is_zero, is_inf, is_nan}); end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL no_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_denormal();
        send_one(32'h00000001, 32'hBF800000);
        tests_run++;
        if ({a_man_norm, a_shift, b_shift} !== {24'h800000, 5'd23, 5'd0}) begin tests_failed++; $display("FAIL denorm_norm got %h %0d %0d exp 800000 23 0", a_man_norm, a_shift, b_shift); end
        exp_e = 10'sd1;
        tests_run++;
        if (exp_sum !== exp_e || result_sign !== 1'b1) begin tests_failed++; $display("FAIL denorm_exp_sign got %0d %b exp 1 1", exp_sum, result_sign); end
        send_one(32'h00800000, 32'h00800000);
        exp_e = -10'sd125;
        tests_run++;
        if (exp_sum !== exp_e) begin tests_failed++; $display("FAIL neg_exp got %0d exp %0d", exp_sum, exp_e); end
    endtask

    task automatic test_specials();
        send_one(32'h00000000, 32'h7F800000);
        tests_run++;
        if ({is_nan, is_inf, is_zero} !== 3'b100) begin tests_failed++; $display("FAIL zero_x_inf got %b exp 100", {is_nan, is_inf, is_zero}); end
        tests_run++;
        if ({a_man_norm, a_shift, b_man_norm} !== {24'h0, 5'd0, 24'h800000}) begin tests_failed++; $display("FAIL zero_sig got %h %0d %h exp 0 0 800000", a_man_norm, a_shift, b_man_norm); end
        send_one(32'h7FC00000, 32'h3F800000);
        tests_run++;
        if ({is_nan, is_inf, is_zero} !== 3'b100) begin tests_failed++; $display("FAIL nan_in got %b exp 100", {is_nan, is_inf, is_zero}); end
        send_one(32'h7F800000, 32'hC0000000);
        tests_run++;
        if ({is_nan, is_inf, is_zero, result_sign} !== 4'b0101) begin tests_failed++; $display("FAIL inf_x_norm got %b exp 0101", {is_nan, is_inf, is_zero, result_sign}); end
        send_one(32'h80000000, 32'h3F800000);
        tests_run++;
        if ({is_nan, is_inf, is_zero, result_sign} !== 4'b0011) begin tests_failed++; $display("FAIL zero_x_norm got %b exp 0011", {is_nan, is_inf, is_zero, result_sign}); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got[$];
        logic [31:0] ops [4];
        for (int k = 0; k < 4; k++) ops[k] = {1'b0, 8'(100 + k), 23'd0};
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            op_a      = ops[sent < 4 ? sent : 3];
            op_b      = 32'h3F800000;
            #1;
            if (cyc == 2 || cyc == 3) begin
                exp_e = 10'sd100;
                tests_run++;
                if (out_valid !== 1'b1 || exp_sum !== exp_e) begin tests_failed++; $display("FAIL stall_hold c%0d got %b %0d exp 1 100", cyc, out_valid, exp_sum); end
                tests_run++;
                if (in_ready !== 1'b0 || sent != 2) begin tests_failed++; $display("FAIL stall_ready c%0d got %b sent %0d exp 0 2", cyc, in_ready, sent); end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got.push_back(int'(exp_sum));
        end
        in_valid = 1'b0;
        tests_run++;
        if (got.size() != 4) begin tests_failed++; $display("FAIL b2b_count got %0d exp 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            tests_run++;
            if (got[k] != 100 + k) begin tests_failed++; $display("FAIL b2b_order[%0d] got %0d exp %0d", k, got[k], 100 + k); end
        end
    endtask

    task automatic test_reset_inflight();
        int stale = 0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
        @(posedge clk); #1;
        op_a = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL inflight_pre got %b exp 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL async_reset got %b %b exp 0 0", out_valid, in_ready); end
        tests_run++;
        if ({a_man_norm, exp_sum} !== 34'd0) begin tests_failed++; $display("FAIL async_reset_data got %h %0d exp 0 0", a_man_norm, exp_sum); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid !== 1'b0) stale++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (stale != 0) begin tests_failed++; $display("FAIL stale_output got %0d exp 0", stale); end
    endtask

    task automatic test_half();
        @(posedge clk); #1;
        h_in_valid = 1'b1; h_op_a = 16'h3C00; h_op_b = 16'h0001;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (h_out_valid !== 1'b1) begin tests_failed++; $display("FAIL half_valid got %b exp 1", h_out_valid); end
        tests_run++;
        if ({h_b_man_norm, h_b_shift, h_a_man_norm} !== {11'h400, 4'd10, 11'h400}) begin tests_failed++; $display("FAIL half_norm got %h %0d %h exp 400 10 400", h_b_man_norm, h_b_shift, h_a_man_norm); end
        tests_run++;
        if (h_exp_sum !== 7'sd1) begin tests_failed++; $display("FAIL half_exp got %0d exp 1", h_exp_sum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_denormal();
        test_specials();
        test_back_to_back();
        test_reset_inflight();
        test_half();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
